// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, helpers and types for the pipelined CLA adder.
// The stage bundle is sized for the widest supported adder (MAX_W bits);
// narrower instances leave the upper bits at zero.
package cla_pkg;

  localparam int SLICE_W = 4;
  localparam int MAX_W   = 64;

  function automatic int stage_count(input int width);
    return width / SLICE_W;
  endfunction

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic             c3;
    logic [MAX_W-1:0] sum;
    logic [MAX_W-1:0] a;
    logic [MAX_W-1:0] b;
  } stage_t;

endpackage

// File: rtl/cla_slice4.sv
// cla_slice4: combinational 4-bit carry-lookahead slice. Besides the sum and
// carry-out it exposes the carry into its top bit, which the adder's last
// stage uses to detect signed overflow.
module cla_slice4
  import cla_pkg::*;
(
  input  logic [SLICE_W-1:0] a_i,
  input  logic [SLICE_W-1:0] b_i,
  input  logic               ci_i,
  output logic [SLICE_W-1:0] s_o,
  output logic               co_o,
  output logic               c3_o
);

  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] p;
  logic [SLICE_W:0]   c;

  // Generate/propagate terms and fully flattened lookahead carries
  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = ci_i;
    c[1] = g[0] | (p[0] & ci_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci_i);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci_i);
    s_o  = p ^ c[SLICE_W-1:0];
    co_o = c[4];
    c3_o = c[3];
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: streaming WIDTH-bit adder, one 4-bit CLA slice per pipeline
// stage with the carry registered between stages. A single advance signal
// moves or freezes the whole pipe, so in_ready depends only on the output slot.
// WIDTH must be a multiple of 4 and no larger than cla_pkg::MAX_W.
// Optional feature macro: CLA_PIPE_OVF_EN adds the signed-overflow output ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N = stage_count(WIDTH);

  stage_t stage_q [N];
  stage_t stage_d [N];
  logic   adv;

  // The pipe moves whenever the output slot is empty or being drained
  always_comb begin
    adv      = !stage_q[N-1].valid || out_ready;
    in_ready = adv;
  end

  for (genvar k = 0; k < N; k++) begin : g_stage
    stage_t             src;
    stage_t             nxt;
    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;
    logic               slice_c3;

    if (k == 0) begin : g_first
      // Stage 0 takes fresh operands, zero-extended into the bundle
      always_comb begin
        src              = '0;
        src.valid        = in_valid;
        src.carry        = cin;
        src.a[WIDTH-1:0] = a;
        src.b[WIDTH-1:0] = b;
      end
    end else begin : g_rest
      assign src = stage_q[k-1];
    end

    cla_slice4 u_slice (
      .a_i  (src.a[k*SLICE_W +: SLICE_W]),
      .b_i  (src.b[k*SLICE_W +: SLICE_W]),
      .ci_i (src.carry),
      .s_o  (slice_s),
      .co_o (slice_co),
      .c3_o (slice_c3)
    );

    // Forward the predecessor bundle with this slice's sum bits and carries filled in
    always_comb begin
      nxt                            = src;
      nxt.carry                      = slice_co;
      nxt.c3                         = slice_c3;
      nxt.sum[k*SLICE_W +: SLICE_W]  = slice_s;
    end

    assign stage_d[k] = nxt;
  end

  // Stage registers: clear on reset, shift together on advance, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[N-1].valid;
  assign sum       = stage_q[N-1].sum[WIDTH-1:0];
  assign cout      = stage_q[N-1].carry;
`ifdef CLA_PIPE_OVF_EN
  assign ovf       = stage_q[N-1].c3 ^ stage_q[N-1].carry;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: directed self-checking bench for the 16-bit pipelined
// CLA adder (4 stages). Overflow checks are compiled in with CLA_PIPE_OVF_EN.
module tb_cla_pipe_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef CLA_PIPE_OVF_EN
  logic             ovf;
`endif

  int nVectors = 0;
  int nMiss    = 0;

  cla_pipe_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef CLA_PIPE_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    nVectors++;
    if (out_valid !== 1'b0) begin
      nMiss++; $display("[TB] FAIL reset_out_valid: got %b, expected 0", out_valid);
    end
    nVectors++;
    if (sum !== 16'h0000) begin
      nMiss++; $display("[TB] FAIL reset_sum: got %h, expected 0000", sum);
    end
    nVectors++;
    if (cout !== 1'b0) begin
      nMiss++; $display("[TB] FAIL reset_cout: got %b, expected 0", cout);
    end
    nVectors++;
    if (in_ready !== 1'b1) begin
      nMiss++; $display("[TB] FAIL reset_in_ready: got %b, expected 1", in_ready);
    end
`ifdef CLA_PIPE_OVF_EN
    nVectors++;
    if (ovf !== 1'b0) begin
      nMiss++; $display("[TB] FAIL reset_ovf: got %b, expected 0", ovf);
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    a        = 16'h1234;
    b        = 16'h4321;
    cin      = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    nVectors++;
    if (lat !== 4) begin
      nMiss++; $display("[TB] FAIL basic_latency: got %0d, expected 4", lat);
    end
    nVectors++;
    if (sum !== 16'h5556) begin
      nMiss++; $display("[TB] FAIL basic_sum: got %h, expected 5556", sum);
    end
    nVectors++;
    if (cout !== 1'b0) begin
      nMiss++; $display("[TB] FAIL basic_cout: got %b, expected 0", cout);
    end
    tick();
    nVectors++;
    if (out_valid !== 1'b0) begin
      nMiss++; $display("[TB] FAIL basic_no_dup: got %b, expected 0", out_valid);
    end
  endtask

  task automatic test_carry;
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic        tc [4];
    logic [15:0] es [4];
    logic        ec [4];
    int          lat;
    ta[0] = 16'hFFFF; tb[0] = 16'h0001; tc[0] = 1'b0; es[0] = 16'h0000; ec[0] = 1'b1;
    ta[1] = 16'hFFFF; tb[1] = 16'hFFFF; tc[1] = 1'b1; es[1] = 16'hFFFF; ec[1] = 1'b1;
    ta[2] = 16'h0000; tb[2] = 16'h0000; tc[2] = 1'b1; es[2] = 16'h0001; ec[2] = 1'b0;
    ta[3] = 16'h0FFF; tb[3] = 16'hF001; tc[3] = 1'b0; es[3] = 16'h0000; ec[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a        = ta[i];
      b        = tb[i];
      cin      = tc[i];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      nVectors++;
      if (lat !== 4) begin
        nMiss++; $display("[TB] FAIL carry_latency[%0d]: got %0d, expected 4", i, lat);
      end
      nVectors++;
      if (sum !== es[i]) begin
        nMiss++; $display("[TB] FAIL carry_sum[%0d]: got %h, expected %h", i, sum, es[i]);
      end
      nVectors++;
      if (cout !== ec[i]) begin
        nMiss++; $display("[TB] FAIL carry_cout[%0d]: got %b, expected %b", i, cout, ec[i]);
      end
`ifdef CLA_PIPE_OVF_EN
      nVectors++;
      if (ovf !== 1'b0) begin
        nMiss++; $display("[TB] FAIL carry_ovf[%0d]: got %b, expected 0", i, ovf);
      end
`endif
      tick();
    end
  endtask

`ifdef CLA_PIPE_OVF_EN
  task automatic test_ovf;
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [15:0] es [4];
    logic        ec [4];
    int          lat;
    ta[0] = 16'h7FFF; tb[0] = 16'h0001; es[0] = 16'h8000; ec[0] = 1'b0;
    ta[1] = 16'h8000; tb[1] = 16'h8000; es[1] = 16'h0000; ec[1] = 1'b1;
    ta[2] = 16'h4000; tb[2] = 16'h4000; es[2] = 16'h8000; ec[2] = 1'b0;
    ta[3] = 16'h8000; tb[3] = 16'hFFFF; es[3] = 16'h7FFF; ec[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a        = ta[i];
      b        = tb[i];
      cin      = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat      = 1;
      while (out_valid !== 1'b1 && lat < 20) begin
        tick();
        lat++;
      end
      nVectors++;
      if (sum !== es[i]) begin
        nMiss++; $display("[TB] FAIL ovf_sum[%0d]: got %h, expected %h", i, sum, es[i]);
      end
      nVectors++;
      if (cout !== ec[i]) begin
        nMiss++; $display("[TB] FAIL ovf_cout[%0d]: got %b, expected %b", i, cout, ec[i]);
      end
      nVectors++;
      if (ovf !== 1'b1) begin
        nMiss++; $display("[TB] FAIL ovf_flag[%0d]: got %b, expected 1", i, ovf);
      end
      tick();
    end
  endtask
`endif

  task automatic test_back_to_back;
    int          first;
    int          last;
    int          got;
    logic [15:0] expSum;
    first     = -1;
    last      = -1;
    got       = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        a        = 16'(c);
        b        = 16'(c * 16'h1111);
        cin      = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (out_valid === 1'b1) begin
        expSum = 16'(got * 16'h1112);
        nVectors++;
        if (got >= 8) begin
          nMiss++; $display("[TB] FAIL b2b_extra: got result %0d, expected only 8", got);
        end else if (sum !== expSum || cout !== 1'b0) begin
          nMiss++; $display("[TB] FAIL b2b_result[%0d]: got %b_%h, expected 0_%h", got, cout, sum, expSum);
        end
        if (first < 0) first = c;
        last = c;
        got++;
      end
    end
    nVectors++;
    if (got !== 8) begin
      nMiss++; $display("[TB] FAIL b2b_count: got %0d, expected 8", got);
    end
    nVectors++;
    if (first !== 3) begin
      nMiss++; $display("[TB] FAIL b2b_first_cycle: got %0d, expected 3", first);
    end
    nVectors++;
    if (last !== 10) begin
      nMiss++; $display("[TB] FAIL b2b_last_cycle: got %0d, expected 10", last);
    end
  endtask

  task automatic test_stall;
    localparam int M = 10;
    bit          pat [4];
    logic [16:0] sb [$];
    logic [16:0] expect17;
    logic [15:0] heldSum;
    logic        heldCout;
    logic        expReady;
    bit          holdPrev;
    int          idx;
    int          emitted;
    int          c;
    pat      = '{1'b1, 1'b0, 1'b0, 1'b1};
    idx      = 0;
    emitted  = 0;
    c        = 0;
    holdPrev = 1'b0;
    heldSum  = '0;
    heldCout = 1'b0;
    while (emitted < M && c < 150) begin
      if (holdPrev) begin
        nVectors++;
        if (out_valid !== 1'b1 || sum !== heldSum || cout !== heldCout) begin
          nMiss++; $display("[TB] FAIL stall_hold: got v=%b %b_%h, expected v=1 %b_%h", out_valid, cout, sum, heldCout, heldSum);
        end
      end
      out_ready = pat[c % 4];
      if (idx < M) begin
        in_valid = 1'b1;
        a        = 16'(idx * 16'h1E3F + 16'h0F00);
        b        = 16'(16'hFFFF - idx * 16'h0707);
        cin      = idx[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      expReady = (out_valid === 1'b1) ? out_ready : 1'b1;
      nVectors++;
      if (in_ready !== expReady) begin
        nMiss++; $display("[TB] FAIL stall_in_ready: got %b, expected %b", in_ready, expReady);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        nVectors++;
        if (sb.size() == 0) begin
          nMiss++; $display("[TB] FAIL stall_extra: got unexpected %b_%h, expected none", cout, sum);
        end else begin
          expect17 = sb.pop_front();
          if ({cout, sum} !== expect17) begin
            nMiss++; $display("[TB] FAIL stall_result[%0d]: got %h, expected %h", emitted, {cout, sum}, expect17);
          end
        end
        emitted++;
      end
      holdPrev = (out_valid === 1'b1) && (out_ready === 1'b0);
      heldSum  = sum;
      heldCout = cout;
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        sb.push_back({1'b0, a} + {1'b0, b} + {16'h0000, cin});
        idx++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    nVectors++;
    if (emitted !== M) begin
      nMiss++; $display("[TB] FAIL stall_count: got %0d, expected %0d", emitted, M);
    end
    nVectors++;
    if (sb.size() !== 0) begin
      nMiss++; $display("[TB] FAIL stall_leftover: got %0d, expected 0", sb.size());
    end
    nVectors++;
    if (out_valid !== 1'b0) begin
      nMiss++; $display("[TB] FAIL stall_no_dup: got %b, expected 0", out_valid);
    end
  endtask

  task automatic test_reset_flush;
    int seen;
    int lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      a        = 16'(16'h0101 * (i + 1));
      b        = 16'h0F0F;
      cin      = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    nVectors++;
    if (out_valid !== 1'b0) begin
      nMiss++; $display("[TB] FAIL flush_out_valid: got %b, expected 0", out_valid);
    end
    nVectors++;
    if (sum !== 16'h0000 || cout !== 1'b0) begin
      nMiss++; $display("[TB] FAIL flush_data: got %b_%h, expected 0_0000", cout, sum);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid === 1'b1) seen++;
    end
    nVectors++;
    if (seen !== 0) begin
      nMiss++; $display("[TB] FAIL flush_ghosts: got %0d, expected 0", seen);
    end
    a        = 16'h0F0F;
    b        = 16'h00F1;
    cin      = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    nVectors++;
    if (lat !== 4) begin
      nMiss++; $display("[TB] FAIL flush_after_latency: got %0d, expected 4", lat);
    end
    nVectors++;
    if (sum !== 16'h1000 || cout !== 1'b0) begin
      nMiss++; $display("[TB] FAIL flush_after_result: got %b_%h, expected 0_1000", cout, sum);
    end
    tick();
  endtask

  // Run every scenario in order, then report
  initial begin
    test_reset();
    test_basic();
    test_carry();
`ifdef CLA_PIPE_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_stall();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
